trap_sequencer: RTL and testbench

Interrupt/trap sequencer for the 5-stage RV32 pipeline. It samples the DMA and watchdog interrupt lines and decides, in the cycle an instruction sits in EXE, whether to take a trap, execute `mret`, or park the core in WFI. It then drives the PC redirect, the pipeline flushes and the CSR update strobes. It sits beside the EXE-stage branch controller; its redirect has priority over the branch PC mux.

---
 rtl/trap_pkg.sv | 24 ++
 rtl/trap_sequencer.sv | 142 ++++++++++++++
 tb/tb_trap_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared trap definitions: sequencer states, mcause encodings and small helpers.
// The CSR block imports this package as well.
package trap_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHADOW = 2'd1,
        SLEEP  = 2'd2
    } trap_state_e;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    // External interrupt outranks the timer when both are pending.
    function automatic logic [31:0] trap_cause_sel(input logic ext_pending);
        return ext_pending ? CAUSE_MEI : CAUSE_MTI;
    endfunction

    // Direct-mode vector: low two bits of the base are not part of the address.
    function automatic logic [31:0] vector_align(input logic [31:0] base);
        return base & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/trap_sequencer.sv
// EXE-stage interrupt/trap sequencer: decides trap, mret or WFI sleep and drives
// PC redirect, pipeline flushes and CSR strobes for the 5-stage RV32 core.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DMA_interrupt,
    input  logic        WDT_timeout,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic [31:0] mtvec_base,
    input  logic [31:0] mepc,
    input  logic        exe_valid,
    input  logic [31:0] exe_pc,
    input  logic        exe_mret,
    input  logic        exe_wfi,
    input  logic        im_stall,
    input  logic        dm_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_ifid,
    output logic        flush_idexe,
    output logic        kill_exe,
    output logic        hold_pc,
    output logic        trap_take,
    output logic [31:0] trap_epc,
    output logic [31:0] trap_cause,
    output logic        mret_take,
    output logic        sleeping
);

    trap_state_e state_r;
    trap_state_e next_state_s;
    logic [31:0] wake_pc_r;
    logic [31:0] wake_pc_next_s;

    logic        advance_s;
    logic        pend_ext_s;
    logic        pend_tmr_s;
    logic        pend_s;
    logic        take_s;
    logic [31:0] vector_pc_s;

    assign advance_s   = !im_stall && !dm_stall;
    assign pend_ext_s  = DMA_interrupt & mie_meie;
    assign pend_tmr_s  = WDT_timeout & mie_mtie;
    assign pend_s      = pend_ext_s | pend_tmr_s;
    assign take_s      = pend_s & mstatus_mie;
    assign vector_pc_s = vector_align((mtvec_base == 32'd0) ? RESET_PC : mtvec_base);

    // Sleep status and PC hold; hold persists through stalls and drops on the wake cycle.
    assign sleeping = !rst && (state_r == SLEEP);
    assign hold_pc  = !rst && (state_r == SLEEP) && !(advance_s && pend_s);

    // Per-cycle decision: next state, wake PC latch and all redirect/flush/CSR strobes.
    always_comb begin
        next_state_s   = state_r;
        wake_pc_next_s = wake_pc_r;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        flush_ifid     = 1'b0;
        flush_idexe    = 1'b0;
        kill_exe       = 1'b0;
        trap_take      = 1'b0;
        trap_epc       = 32'd0;
        trap_cause     = 32'd0;
        mret_take      = 1'b0;
        if (rst || !advance_s) begin
            next_state_s = state_r;
        end else begin
            case (state_r)
                RUN, SHADOW: begin
                    // Interrupts stay masked in SHADOW until one instruction has executed.
                    if (exe_valid && take_s && (state_r == RUN)) begin
                        trap_take      = 1'b1;
                        trap_epc       = exe_pc;
                        trap_cause     = trap_cause_sel(pend_ext_s);
                        kill_exe       = 1'b1;
                        flush_idexe    = 1'b1;
                        flush_ifid     = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = vector_pc_s;
                        next_state_s   = SHADOW;
                    end else if (exe_valid && exe_mret) begin
                        mret_take      = 1'b1;
                        flush_idexe    = 1'b1;
                        flush_ifid     = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = mepc;
                        next_state_s   = SHADOW;
                    end else if (exe_valid && exe_wfi) begin
                        flush_idexe    = 1'b1;
                        flush_ifid     = 1'b1;
                        wake_pc_next_s = exe_pc + 32'd4;
                        next_state_s   = SLEEP;
                    end else if (exe_valid) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                SLEEP: begin
                    flush_ifid  = 1'b1;
                    flush_idexe = 1'b1;
                    if (pend_s && mstatus_mie) begin
                        trap_take      = 1'b1;
                        trap_epc       = wake_pc_r;
                        trap_cause     = trap_cause_sel(pend_ext_s);
                        redirect_valid = 1'b1;
                        redirect_pc    = vector_pc_s;
                        next_state_s   = SHADOW;
                    end else if (pend_s) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = wake_pc_r;
                        next_state_s   = RUN;
                    end else begin
                        next_state_s = SLEEP;
                    end
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // State and wake-PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RUN;
            wake_pc_r <= 32'd0;
        end else begin
            state_r   <= next_state_s;
            wake_pc_r <= wake_pc_next_s;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed scenarios then randomized traffic,
// expected outputs from a behavioural model, checked by an independent monitor.
module tb_trap_sequencer;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    typedef struct packed {
        logic        rst;
        logic        dma;
        logic        wdt;
        logic        mie;
        logic        meie;
        logic        mtie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        valid;
        logic [31:0] pc;
        logic        mret;
        logic        wfi;
        logic        ims;
        logic        dms;
    } in_t;

    typedef struct packed {
        logic        rv;
        logic [31:0] rpc;
        logic        fif;
        logic        fie;
        logic        kex;
        logic        hold;
        logic        tt;
        logic [31:0] epc;
        logic [31:0] cause;
        logic        mt;
        logic        slp;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DMA_interrupt = 1'b0, WDT_timeout = 1'b0;
    logic        mstatus_mie = 1'b0, mie_meie = 1'b0, mie_mtie = 1'b0;
    logic [31:0] mtvec_base = 32'd0, mepc = 32'd0, exe_pc = 32'd0;
    logic        exe_valid = 1'b0, exe_mret = 1'b0, exe_wfi = 1'b0;
    logic        im_stall = 1'b0, dm_stall = 1'b0;
    logic        redirect_valid, flush_ifid, flush_idexe, kill_exe, hold_pc;
    logic        trap_take, mret_take, sleeping;
    logic [31:0] redirect_pc, trap_epc, trap_cause;

    trap_sequencer #(.RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .DMA_interrupt(DMA_interrupt), .WDT_timeout(WDT_timeout),
        .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie),
        .mtvec_base(mtvec_base), .mepc(mepc),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_mret(exe_mret), .exe_wfi(exe_wfi),
        .im_stall(im_stall), .dm_stall(dm_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_ifid(flush_ifid), .flush_idexe(flush_idexe), .kill_exe(kill_exe),
        .hold_pc(hold_pc), .trap_take(trap_take), .trap_epc(trap_epc),
        .trap_cause(trap_cause), .mret_take(mret_take), .sleeping(sleeping)
    );

    always #5 clk = ~clk;

    // Reference model: "asleep" core, "masked" right after a trap/mret, and the resume PC.
    bit          m_asleep = 1'b0;
    bit          m_masked = 1'b0;
    logic [31:0] m_resume = 32'd0;

    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    function automatic out_t model_step(input in_t s);
        out_t        e;
        logic        ext, tmr, pend, adv;
        logic [31:0] vec;
        e    = '0;
        adv  = !s.ims && !s.dms;
        ext  = s.dma && s.meie;
        tmr  = s.wdt && s.mtie;
        pend = ext || tmr;
        vec  = (s.mtvec == 32'd0) ? TB_RESET_PC : s.mtvec;
        vec[1:0] = 2'b00;
        if (s.rst) begin
            m_asleep = 1'b0;
            m_masked = 1'b0;
            m_resume = 32'd0;
            return e;
        end
        if (m_asleep) begin
            e.slp  = 1'b1;
            e.hold = 1'b1;
            if (adv) begin
                e.fif = 1'b1;
                e.fie = 1'b1;
                if (pend) begin
                    e.hold   = 1'b0;
                    e.rv     = 1'b1;
                    m_asleep = 1'b0;
                    if (s.mie) begin
                        e.tt     = 1'b1;
                        e.epc    = m_resume;
                        e.cause  = ext ? 32'h8000_000B : 32'h8000_0007;
                        e.rpc    = vec;
                        m_masked = 1'b1;
                    end else begin
                        e.rpc    = m_resume;
                        m_masked = 1'b0;
                    end
                end
            end
            return e;
        end
        if (adv && s.valid) begin
            if (!m_masked && s.mie && pend) begin
                e.tt = 1'b1; e.epc = s.pc; e.cause = ext ? 32'h8000_000B : 32'h8000_0007;
                e.kex = 1'b1; e.fie = 1'b1; e.fif = 1'b1; e.rv = 1'b1; e.rpc = vec;
                m_masked = 1'b1;
            end else if (s.mret) begin
                e.mt = 1'b1; e.fie = 1'b1; e.fif = 1'b1; e.rv = 1'b1; e.rpc = s.mepc;
                m_masked = 1'b1;
            end else if (s.wfi) begin
                e.fie = 1'b1; e.fif = 1'b1;
                m_asleep = 1'b1;
                m_masked = 1'b0;
                m_resume = s.pc + 32'd4;
            end else begin
                m_masked = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic drive(input in_t s);
        rst = s.rst; DMA_interrupt = s.dma; WDT_timeout = s.wdt;
        mstatus_mie = s.mie; mie_meie = s.meie; mie_mtie = s.mtie;
        mtvec_base = s.mtvec; mepc = s.mepc; exe_valid = s.valid; exe_pc = s.pc;
        exe_mret = s.mret; exe_wfi = s.wfi; im_stall = s.ims; dm_stall = s.dms;
        exp_q.push_back(model_step(s));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per presented cycle and compares every output.
    always @(negedge clk) begin : monitor
        out_t e, g;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {redirect_valid, redirect_pc, flush_ifid, flush_idexe, kill_exe, hold_pc,
                 trap_take, trap_epc, trap_cause, mret_take, sleeping};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs cycle=%0d got=%h exp=%h (rv rpc fif fie kex hold tt epc cause mt slp)",
                         cycle, g, e);
            end
            cycle++;
        end
    end

    initial begin : stim
        in_t s, b;
        @(posedge clk);
        #1;
        // Reset state
        s = '0; s.rst = 1'b1;
        repeat (3) drive(s);

        // Trap at 0x100, mtvec 0x203
        b = '0; b.mie = 1'b1; b.meie = 1'b1; b.mtie = 1'b1; b.mtvec = 32'h203;
        s = b; s.valid = 1'b1; s.pc = 32'h100; s.dma = 1'b1;
        drive(s);
        // Both lines held through SHADOW: bubbles, one retiring instruction, then retrap
        s = b; s.dma = 1'b1; s.wdt = 1'b1;
        drive(s); drive(s);
        s.valid = 1'b1; s.pc = 32'h104; drive(s);
        s.pc = 32'h108; drive(s);
        s = b; s.valid = 1'b1; s.pc = 32'h200; drive(s);

        // mret with a data stall first
        s = b; s.valid = 1'b1; s.mret = 1'b1; s.mepc = 32'h1234; s.pc = 32'h204; s.dms = 1'b1;
        drive(s);
        s.dms = 1'b0; drive(s);
        s = b; s.valid = 1'b1; s.pc = 32'h1234; drive(s);

        // WFI with MIE=0, timer wake after a stalled pending cycle
        b.mie = 1'b0;
        s = b; s.valid = 1'b1; s.wfi = 1'b1; s.pc = 32'h40; drive(s);
        s = b; drive(s); drive(s);
        s.wdt = 1'b1; s.ims = 1'b1; drive(s);
        s.ims = 1'b0; drive(s);
        s = b; s.valid = 1'b1; s.pc = 32'h44; drive(s);

        // WFI with MIE=1, wake traps with epc 0x44
        b.mie = 1'b1;
        s = b; s.valid = 1'b1; s.wfi = 1'b1; s.pc = 32'h40; drive(s);
        s = b; drive(s);
        s.wdt = 1'b1; drive(s);
        s = b; s.valid = 1'b1; s.pc = 32'h200; drive(s);

        // Reset while sleeping; wfi at top of address space wraps the wake PC
        s = b; s.valid = 1'b1; s.wfi = 1'b1; s.pc = 32'hFFFF_FFFC; drive(s);
        s = b; drive(s);
        s.rst = 1'b1; drive(s);
        s.rst = 1'b0; drive(s);
        s = b; s.valid = 1'b1; s.wfi = 1'b1; s.pc = 32'hFFFF_FFFC; drive(s);
        s = b; s.dma = 1'b1; s.mtvec = 32'd0; drive(s);
        s = b; s.valid = 1'b1; drive(s);

        // Randomized traffic with sticky interrupt lines
        s = '0;
        for (int i = 0; i < 4000; i++) begin
            s.rst   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) s.dma = ~s.dma;
            if ($urandom_range(0, 9) == 0) s.wdt = ~s.wdt;
            s.mie   = ($urandom_range(0, 3) != 0);
            s.meie  = ($urandom_range(0, 4) != 0);
            s.mtie  = ($urandom_range(0, 4) != 0);
            s.mtvec = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
            s.mepc  = $urandom() & 32'hFFFF_FFFC;
            s.valid = ($urandom_range(0, 9) < 7);
            s.pc    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            s.mret  = ($urandom_range(0, 9) == 0);
            s.wfi   = ($urandom_range(0, 7) == 0);
            s.ims   = ($urandom_range(0, 7) == 0);
            s.dms   = ($urandom_range(0, 9) == 0);
            drive(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
